score_keeper: RTL and testbench

SCORE_KEEPER -- requirements
Module: score_keeper

---
 rtl/score_keeper.sv | 164 ++++++++++++++++
 tb/tb_score_keeper.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/score_keeper.sv
// Whack-a-mole score keeper: synchronises and debounces four player buttons,
// classifies each press as a hit or a miss, and keeps a saturating BCD score.
module score_keeper #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned MAX_SCORE       = 999
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  buttons,
   input  logic [3:0]  mole_pos,
   input  logic        mole_valid,
   input  logic        clear,
   output logic [11:0] score_bcd,
   output logic        hit_pulse,
   output logic        miss_pulse
);

   localparam int unsigned NBTN   = 4;
   localparam int unsigned DIGW   = 4;
   localparam int unsigned SCOREW = 3 * DIGW;
   localparam int unsigned CNT_W  = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);

   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [SCOREW-1:0] MAX_BCD  = {DIGW'(MAX_SCORE / 100),
                                             DIGW'((MAX_SCORE / 10) % 10),
                                             DIGW'(MAX_SCORE % 10)};

   logic [NBTN-1:0]  sync1;
   logic [NBTN-1:0]  sync2;
   logic [NBTN-1:0]  db;
   logic [NBTN-1:0]  db_d;
   logic [NBTN-1:0]  press;
   logic [CNT_W-1:0] cnt [NBTN];
   logic             hit_lock;
   logic [NBTN-1:0]  lock_pos;

   logic             any_press_c;
   logic             hit_c;
   logic             miss_c;
   logic [SCOREW-1:0] score_inc_c;
   logic [SCOREW-1:0] score_dec_c;

   // Single-digit BCD step helpers; each reports whether it wrapped.
   function automatic logic [DIGW:0] dig_inc(input logic [DIGW-1:0] d);
      if (d >= DIGW'(9)) return {1'b1, DIGW'(0)};
      return {1'b0, d + DIGW'(1)};
   endfunction

   function automatic logic [DIGW:0] dig_dec(input logic [DIGW-1:0] d);
      if (d == DIGW'(0)) return {1'b1, DIGW'(9)};
      if (d > DIGW'(9))  return {1'b0, DIGW'(9)};
      return {1'b0, d - DIGW'(1)};
   endfunction

   function automatic logic [SCOREW-1:0] bcd_inc(input logic [SCOREW-1:0] v);
      logic [DIGW:0] u;
      logic [DIGW:0] t;
      logic [DIGW:0] h;
      u = dig_inc(v[3:0]);
      t = u[DIGW] ? dig_inc(v[7:4])  : {1'b0, v[7:4]};
      h = t[DIGW] ? dig_inc(v[11:8]) : {1'b0, v[11:8]};
      return {h[DIGW-1:0], t[DIGW-1:0], u[DIGW-1:0]};
   endfunction

   function automatic logic [SCOREW-1:0] bcd_dec(input logic [SCOREW-1:0] v);
      logic [DIGW:0] u;
      logic [DIGW:0] t;
      logic [DIGW:0] h;
      u = dig_dec(v[3:0]);
      t = u[DIGW] ? dig_dec(v[7:4])  : {1'b0, v[7:4]};
      h = t[DIGW] ? dig_dec(v[11:8]) : {1'b0, v[11:8]};
      return {h[DIGW-1:0], t[DIGW-1:0], u[DIGW-1:0]};
   endfunction

   // Two-flop synchronizer on the raw buttons.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= buttons;
         sync2 <= sync1;
      end
   end

   // Per-button debounce: state flips on the edge its run of disagreement reaches the limit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         db <= '0;
         for (int i = 0; i < NBTN; i++) cnt[i] <= '0;
      end else begin
         for (int i = 0; i < NBTN; i++) begin
            if (sync2[i] == db[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CNT_LAST) begin
               cnt[i] <= '0;
               db[i]  <= ~db[i];
            end else begin
               cnt[i] <= cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   // One-cycle press event, the cycle after a debounced rising edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         db_d  <= '0;
         press <= '0;
      end else begin
         db_d  <= db;
         press <= db & ~db_d;
      end
   end

   always_comb begin
      any_press_c = 1'b0;
      hit_c       = 1'b0;
      miss_c      = 1'b0;
      score_inc_c = bcd_inc(score_bcd);
      score_dec_c = bcd_dec(score_bcd);
      any_press_c = |press;
      hit_c       = any_press_c && mole_valid && !hit_lock && (|(press & mole_pos));
      miss_c      = any_press_c && !hit_c;
   end

   // A mole can only be scored once until it moves or disappears.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_lock <= 1'b0;
         lock_pos <= '0;
      end else if (hit_c) begin
         hit_lock <= 1'b1;
         lock_pos <= mole_pos;
      end else if (hit_lock && (!mole_valid || (mole_pos != lock_pos))) begin
         hit_lock <= 1'b0;
      end
   end

   // Score register with saturation; pulses track the scoring action even when held.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         score_bcd  <= '0;
         hit_pulse  <= 1'b0;
         miss_pulse <= 1'b0;
      end else if (clear) begin
         score_bcd  <= '0;
         hit_pulse  <= 1'b0;
         miss_pulse <= 1'b0;
      end else if (hit_c) begin
         hit_pulse  <= 1'b1;
         miss_pulse <= 1'b0;
         if (score_bcd != MAX_BCD) score_bcd <= score_inc_c;
      end else if (miss_c) begin
         hit_pulse  <= 1'b0;
         miss_pulse <= 1'b1;
         if (score_bcd != SCOREW'(0)) score_bcd <= score_dec_c;
      end else begin
         hit_pulse  <= 1'b0;
         miss_pulse <= 1'b0;
      end
   end

endmodule

// File: tb/tb_score_keeper.sv
// Scoreboard bench for score_keeper with DEBOUNCE_CYCLES=4: expected scoring
// events are queued by the stimulus and checked when the DUT pulses.
module tb_score_keeper;

   localparam int unsigned DEB = 4;

   typedef struct packed {
      logic        is_hit;
      logic [11:0] score;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  buttons = '0;
   logic [3:0]  mole_pos = '0;
   logic        mole_valid = 1'b0;
   logic        clear = 1'b0;
   logic [11:0] score_bcd;
   logic        hit_pulse;
   logic        miss_pulse;

   exp_t exp_q[$];
   int   checks = 0;
   int   failures = 0;
   int   pulse_cnt = 0;
   int   pushed = 0;
   int   model = 0;
   int   hole = 0;

   score_keeper #(.DEBOUNCE_CYCLES(DEB), .MAX_SCORE(999)) dut (
      .clk(clk), .rst_n(rst_n), .buttons(buttons), .mole_pos(mole_pos),
      .mole_valid(mole_valid), .clear(clear), .score_bcd(score_bcd),
      .hit_pulse(hit_pulse), .miss_pulse(miss_pulse)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

   function automatic logic [11:0] to_bcd(input int v);
      logic [11:0] r;
      r[11:8] = 4'(v / 100);
      r[7:4]  = 4'((v / 10) % 10);
      r[3:0]  = 4'(v % 10);
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", name, got, want);
      end
   endtask

   task automatic push(input logic is_hit, input logic [11:0] s);
      exp_t e;
      e.is_hit = is_hit;
      e.score  = s;
      exp_q.push_back(e);
      pushed++;
   endtask

   task automatic press(input int h);
      buttons[h] = 1'b1;
      repeat (9) @(negedge clk);
      buttons[h] = 1'b0;
      repeat (8) @(negedge clk);
   endtask

   // Move the mole to the other of holes 0/1 and hit it.
   task automatic hit_next(input logic [11:0] s);
      hole = 1 - hole;
      mole_pos = 4'(1 << hole);
      push(1'b1, s);
      press(hole);
   endtask

   task automatic count_up(input int target);
      while (model < target) begin
         model++;
         hit_next(to_bcd(model));
      end
   endtask

   // Monitor: every pulse must match the next queued expectation.
   always @(negedge clk) begin
      exp_t e;
      if (hit_pulse || miss_pulse) begin
         pulse_cnt++;
         checks++;
         if (hit_pulse && miss_pulse) begin
            failures++;
            $display("FAIL pulse_excl hit=%0b miss=%0b", hit_pulse, miss_pulse);
         end else if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_pulse hit=%0b score=%h", hit_pulse, score_bcd);
         end else begin
            e = exp_q.pop_front();
            if (e.is_hit !== hit_pulse || e.score !== score_bcd) begin
               failures++;
               $display("FAIL event got hit=%0b score=%h exp hit=%0b score=%h",
                        hit_pulse, score_bcd, e.is_hit, e.score);
            end
         end
      end
   end

   initial begin
      int p0;
      int lat;
      repeat (3) @(negedge clk);
      check("reset_score", 32'(score_bcd), 32'h000);
      check("reset_hit", 32'(hit_pulse), 32'd0);
      check("reset_miss", 32'(miss_pulse), 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Scenario 1: held press on the shown mole
      mole_valid = 1'b1;
      mole_pos = 4'b0100;
      p0 = pulse_cnt;
      push(1'b1, 12'h001);
      buttons[2] = 1'b1;
      repeat (10) @(negedge clk);
      buttons[2] = 1'b0;
      repeat (8) @(negedge clk);
      check("s1_one_pulse", 32'(pulse_cnt - p0), 32'd1);
      check("s1_score", 32'(score_bcd), 32'h001);

      // Scenario 2: bouncing button never settles
      mole_pos = 4'b0010;
      p0 = pulse_cnt;
      for (int i = 0; i < 10; i++) begin
         buttons[1] = ~buttons[1];
         repeat (2) @(negedge clk);
      end
      buttons[1] = 1'b0;
      repeat (8) @(negedge clk);
      check("s2_no_pulse", 32'(pulse_cnt - p0), 32'd0);
      check("s2_score", 32'(score_bcd), 32'h001);

      // Scenario 5: hit lock
      mole_pos = 4'b0100;
      push(1'b1, 12'h002);
      press(2);
      push(1'b0, 12'h001);
      press(2);
      mole_pos = 4'b1000;
      push(1'b1, 12'h002);
      press(3);
      check("s5_score", 32'(score_bcd), 32'h002);

      // Scenario 4 (low end): wrong button, then miss at zero
      push(1'b0, 12'h001);
      press(0);
      push(1'b0, 12'h000);
      press(0);
      p0 = pulse_cnt;
      push(1'b0, 12'h000);
      press(0);
      check("s4_zero_sat_score", 32'(score_bcd), 32'h000);
      check("s4_zero_sat_pulse", 32'(pulse_cnt - p0), 32'd1);

      // Scenario 3/4: carries and borrows around 099/100
      model = 0;
      count_up(99);
      check("s3_score_099", 32'(score_bcd), 32'h099);
      hit_next(12'h100);
      check("s3_carry", 32'(score_bcd), 32'h100);
      push(1'b0, 12'h099);
      press(3);
      check("s4_borrow", 32'(score_bcd), 32'h099);
      model = 99;
      count_up(999);
      check("s3_score_999", 32'(score_bcd), 32'h999);
      p0 = pulse_cnt;
      hit_next(12'h999);
      check("s3_max_sat_score", 32'(score_bcd), 32'h999);
      check("s3_max_sat_pulse", 32'(pulse_cnt - p0), 32'd1);

      // Scenario 6: clear wins over a coinciding hit
      hole = 1 - hole;
      mole_pos = 4'(1 << hole);
      p0 = pulse_cnt;
      clear = 1'b1;
      press(hole);
      clear = 1'b0;
      check("s6_clear_score", 32'(score_bcd), 32'h000);
      check("s6_clear_no_pulse", 32'(pulse_cnt - p0), 32'd0);
      hit_next(12'h001);
      check("s6_post_clear_hit", 32'(score_bcd), 32'h001);

      // Scenario 6: reset mid-debounce, button held through release
      buttons[hole] = 1'b1;
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rst_async_score", 32'(score_bcd), 32'h000);
      check("rst_async_hit", 32'(hit_pulse), 32'd0);
      check("rst_async_miss", 32'(miss_pulse), 32'd0);
      repeat (3) @(negedge clk);
      push(1'b1, 12'h001);
      rst_n = 1'b1;
      lat = 0;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk);
         #1;
         if (hit_pulse) begin
            lat = k;
            break;
         end
      end
      check("rst_release_latency", 32'(lat), 32'(DEB + 4));
      @(negedge clk);
      buttons = '0;
      repeat (10) @(negedge clk);
      check("final_score", 32'(score_bcd), 32'h001);
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      check("pulse_total", 32'(pulse_cnt), 32'(pushed));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
